// File: rtl/ram16_arb_pkg.sv
// rtl/ram16_arb_pkg.sv - shared types and defaults for the RAM16 arbiter
//
// Holds the FSM state enum, the default DATA_W/ADDR_W values and the
// width of the post-reset clear counter.
// Optional feature macro: RAM16_ARB_CLEAR_EN (adds the CLEAR state).
package ram16_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Clear counter needs one extra bit so that its MSB flags "all words done".
  function automatic int clr_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

  localparam int CLR_CNT_W_DEF = clr_cnt_w(ADDR_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
`ifdef RAM16_ARB_CLEAR_EN
    ,
    ST_CLEAR  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/ram16_arbiter_rr_select.sv
// rtl/ram16_arbiter_rr_select.sv - two-way round-robin picker
//
// Ports:
//   req_a, req_b  in   requests from A and B
//   last_b        in   1 = B was served last, 0 = A was served last
//   pick_b        out  1 = B wins, 0 = A wins (only meaningful if a req is high)
module rr_select (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic pick_b
);

  // B wins when it is the only requester, or when both request and A was
  // the one served last.
  assign pick_b = req_b & (~req_a | ~last_b);

endmodule

// File: rtl/ram16_arbiter.sv
// rtl/ram16_arbiter.sv - two-requester round-robin arbiter in front of a RAM16
//
// Optional feature macro: RAM16_ARB_CLEAR_EN (post-reset clear of all words).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_x/we_x/addr_x/wdata_x  requester x access (x = a, b), held until ack_x
//   gnt_x                      requester x owns the RAM (ACCESS and RESP)
//   ack_x                      one-cycle completion pulse
//   rdata_x                    read result, valid while ack_x is high
//   ram_addr/ram_in/ram_write  drive the external RAM16
//   ram_out                    RAM16 read data
//   busy                       clear sequence in progress
module ram16_arbiter
  import ram16_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

`ifdef RAM16_ARB_CLEAR_EN
  localparam int CLR_W = clr_cnt_w(ADDR_W);
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t state;
  logic   owner_b;  // requester that owns the current transaction
  logic   last_b;   // last served requester; reset value 1 gives A priority
  logic   pick_b;
  logic   any_req;

  assign any_req = req_a | req_b;

  rr_select u_rr_select (
    .req_a  (req_a),
    .req_b  (req_b),
    .last_b (last_b),
    .pick_b (pick_b)
  );

`ifdef RAM16_ARB_CLEAR_EN
  logic [CLR_W-1:0] clr_cnt;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_STATE;
      owner_b   <= 1'b0;
      last_b    <= 1'b1;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      ram_addr  <= '0;
      ram_in    <= '0;
      ram_write <= 1'b0;
`ifdef RAM16_ARB_CLEAR_EN
      clr_cnt   <= '0;
      busy      <= 1'b0;
`endif
    end else begin
      // ack is a single-cycle pulse; only the RESP branch raises it.
      ack_a <= 1'b0;
      ack_b <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner_b   <= pick_b;
            gnt_a     <= ~pick_b;
            gnt_b     <= pick_b;
            ram_addr  <= pick_b ? addr_b  : addr_a;
            ram_in    <= pick_b ? wdata_b : wdata_a;
            ram_write <= pick_b ? we_b    : we_a;
            state     <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          // ram_write still holds the registered we, so it tells read from write.
          if (!ram_write) begin
            if (owner_b) begin
              rdata_b <= ram_out;
            end else begin
              rdata_a <= ram_out;
            end
          end
          ram_write <= 1'b0;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          gnt_a  <= 1'b0;
          gnt_b  <= 1'b0;
          ack_a  <= ~owner_b;
          ack_b  <= owner_b;
          last_b <= owner_b;
          state  <= ST_IDLE;
        end

`ifdef RAM16_ARB_CLEAR_EN
        ST_CLEAR: begin
          // MSB of clr_cnt set means every word has been written.
          if (!clr_cnt[ADDR_W]) begin
            ram_write <= 1'b1;
            ram_addr  <= clr_cnt[ADDR_W-1:0];
            ram_in    <= '0;
            busy      <= 1'b1;
            clr_cnt   <= clr_cnt + 1'b1;
          end else begin
            ram_write <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram16_arbiter.sv
// tb/tb_ram16_arbiter.sv - scoreboard bench for ram16_arbiter with a RAM16 model
module tb_ram16_arbiter;

`ifdef RAM16_ARB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [3:0]  addr_a = '0, addr_b = '0;
  logic [15:0] wdata_a = '0, wdata_b = '0;
  logic        gnt_a, gnt_b, ack_a, ack_b;
  logic [15:0] rdata_a, rdata_b;
  logic [3:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_write;
  logic [15:0] ram_out;
  logic        busy;

  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_b;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram16_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .ack_a(ack_a), .ack_b(ack_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_write(ram_write),
    .ram_out(ram_out), .busy(busy)
  );

  // RAM16 model: combinational read, write on the clock edge.
  logic [15:0] mem [16];
  assign ram_out = mem[ram_addr];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (ram_write) mem[ram_addr] <= ram_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ack and checks side and read data.
  always @(negedge clk) begin
    exp_t e;
    check("gnt_exclusive", {31'd0, gnt_a & gnt_b}, 32'd0);
    if (ack_a || ack_b) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, ack_b, ack_a}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_side", {30'd0, ack_b, ack_a}, e.is_b ? 32'd2 : 32'd1);
        check("ack_rdata", {16'd0, e.is_b ? rdata_b : rdata_a}, {16'd0, e.data});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ctrl", {27'd0, gnt_a, gnt_b, ack_a, ack_b, ram_write}, 32'd0);
    check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
    check("rst_ram_in", {16'd0, ram_in}, 32'd0);
    check("rst_rdata", {rdata_a, rdata_b}, 32'd0);
    reset = 1'b0;
    repeat (CLR ? 20 : 1) @(negedge clk);
  endtask

  // Issue one access, wait for its ack (bounded), check the 3-cycle latency.
  task automatic issue(input bit is_b, input bit we, input logic [3:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_rd, input string name);
    int cyc = 0;
    bit got = 0;
    sb.push_back('{is_b, exp_rd});
    if (is_b) begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    end
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      got = is_b ? ack_b : ack_a;
    end
    if (is_b) req_b = 1'b0; else req_a = 1'b0;
    check({name, "_latency"}, cyc, 32'd3);
  endtask

  initial begin
    int cyc;
    int n;
    int bcnt;
    bit saw_gb;
    bit got;
    logic [3:0] order;
    bit prev_ga, prev_gb;

    #1 reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_addr = 4'(i); pre_data = 16'(i * 16'h0100);
    end
    @(negedge clk);
    pre_en = 1'b0;
    do_reset();

    // Write then read back, write leaves rdata untouched.
    issue(0, 1, 4'd5, 16'hBEEF, 16'h0000, "a_wr5");
    issue(0, 0, 4'd5, 16'h0000, 16'hBEEF, "a_rd5");
    issue(0, 1, 4'd5, 16'h1111, 16'hBEEF, "a_wr5_keep");
    issue(1, 0, 4'd5, 16'h0000, 16'h1111, "b_rd5");
    // Boundary addresses, back-to-back.
    issue(0, 1, 4'd15, 16'hF00F, 16'hBEEF, "a_wr15");
    issue(0, 1, 4'd0,  16'h0A0A, 16'hBEEF, "a_wr0");
    issue(1, 0, 4'd15, 16'h0000, 16'hF00F, "b_rd15");
    issue(1, 0, 4'd0,  16'h0000, 16'h0A0A, "b_rd0");
    issue(0, 0, 4'd15, 16'h0000, 16'hF00F, "a_rd15");
    issue(0, 0, 4'd0,  16'h0000, 16'h0A0A, "a_rd0");
    issue(1, 0, 4'd7,  16'h0000, CLR ? 16'h0000 : 16'h0700, "b_rd7");

    // Contention from reset: both held, expect A,B,A,B.
    do_reset();
    sb.push_back('{0, CLR ? 16'h0000 : 16'hF00F});
    sb.push_back('{1, CLR ? 16'h0000 : 16'h0A0A});
    sb.push_back('{0, CLR ? 16'h0000 : 16'hF00F});
    sb.push_back('{1, CLR ? 16'h0000 : 16'h0A0A});
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd15;
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd0;
    n = 0; cyc = 0; order = '0; prev_ga = 0; prev_gb = 0;
    while (n < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (gnt_a && !prev_ga) order = {order[2:0], 1'b0};
      if (gnt_b && !prev_gb) order = {order[2:0], 1'b1};
      prev_ga = gnt_a; prev_gb = gnt_b;
      if (ack_a || ack_b) n++;
    end
    req_a = 1'b0; req_b = 1'b0;
    check("contend_order", {28'd0, order}, 32'h5);
    check("contend_cycles", cyc, 32'd12);

    // req_b dropped during ACCESS still completes.
    sb.push_back('{1, CLR ? 16'h0000 : 16'h0700});
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd7;
    @(negedge clk);
    check("drop_acc_gnt_b", {31'd0, gnt_b}, 32'd1);
    req_b = 1'b0;
    got = 0; cyc = 1;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      got = ack_b;
    end
    check("drop_acc_ack_b", cyc, 32'd3);

    // B loses to A (B served last), drops before its grant: never granted.
    sb.push_back('{0, CLR ? 16'h0000 : 16'hF00F});
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd15;
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd0;
    @(negedge clk);
    check("drop_idle_gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
    req_b = 1'b0;
    saw_gb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw_gb |= gnt_b;
      if (ack_a) req_a = 1'b0;
    end
    req_a = 1'b0;
    check("drop_idle_no_gnt_b", {31'd0, saw_gb}, 32'd0);

    // Reset during a write ACCESS: write dropped at once, no ack, no commit.
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; wdata_a = 16'h3333;
    @(negedge clk);
    check("mid_acc_write", {11'd0, ram_write, ram_addr, ram_in}, {11'd0, 1'b1, 4'd3, 16'h3333});
    reset = 1'b1;
    #1;
    check("mid_rst_write_low", {29'd0, ram_write, gnt_a, ack_a}, 32'd0);
    req_a = 1'b0; we_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (CLR ? 20 : 1) @(negedge clk);
    issue(0, 0, 4'd3, 16'h0000, CLR ? 16'h0000 : 16'h0300, "after_rst_rd3");

`ifdef RAM16_ARB_CLEAR_EN
    @(negedge clk);
    pre_en = 1'b1; pre_addr = 4'd9; pre_data = 16'h1234;
    @(negedge clk);
    pre_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    check("clear_busy_cycles", bcnt, 32'd16);
    issue(0, 0, 4'd9, 16'h0000, 16'h0000, "clear_rd9");
`else
    bcnt = 0;
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
